// File: rtl/spi_flash_boot_loader_if.sv
// Boot loader bus bundle: SPI flash pins toward the external flash, the
// instruction-memory write port, and the core release handshake.
interface spi_flash_boot_loader_if;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_cs;
    logic        itcm_we;
    logic [11:0] itcm_addr;
    logic [31:0] itcm_wdata;
    logic        core_hold;
    logic        boot_done;

    // The loader drives the SPI pins, the ITCM port and the core handshake.
    modport master (
        output spi_sck,
        output spi_mosi,
        input  spi_miso,
        output spi_cs,
        output itcm_we,
        output itcm_addr,
        output itcm_wdata,
        output core_hold,
        output boot_done
    );

    // Flash device / ITCM / core side of the same bundle.
    modport slave (
        input  spi_sck,
        input  spi_mosi,
        output spi_miso,
        input  spi_cs,
        input  itcm_we,
        input  itcm_addr,
        input  itcm_wdata,
        input  core_hold,
        input  boot_done
    );
endinterface

// File: rtl/spi_flash_boot_loader.sv
// SPI flash boot loader. Holds the core in reset, issues a single READ (0x03)
// to the flash, copies BOOT_WORDS little-endian words into the ITCM from byte
// address 0, then releases the core. SPI mode 0: MOSI changes on the SCK
// falling edge, MISO is sampled on the SCK rising edge.
module spi_flash_boot_loader #(
    parameter int          BOOT_WORDS      = 1024,
    parameter logic [23:0] FLASH_BASE_ADDR = 24'h000000,
    parameter int          SCK_DIV         = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    spi_flash_boot_loader_if.master bus
);
    localparam logic [7:0]  DIV_LAST  = 8'(SCK_DIV - 1);
    localparam logic [9:0]  LAST_WORD = 10'(BOOT_WORDS - 1);
    localparam logic [31:0] READ_CMD  = {8'h03, FLASH_BASE_ADDR};

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        CMD,
        DATA,
        CS_HOLD,
        DONE
    } state_t;

    state_t      state_reg;
    logic [7:0]  div_cnt_reg;     // clk cycles within the current SCK half-period
    logic [4:0]  bit_cnt_reg;     // bit position within command or current word
    logic [31:0] cmd_sr_reg;      // command/address shift register
    logic [6:0]  byte_sr_reg;     // first seven bits of the byte being received
    logic [23:0] word_sr_reg;     // completed lower bytes of the word, byte 0 lowest
    logic [9:0]  word_idx_reg;
    logic        last_word_reg;   // final word has been written

    logic        sck_reg;
    logic        mosi_reg;
    logic        cs_reg;
    logic        we_reg;
    logic [11:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        hold_reg;
    logic        done_reg;

    logic        half_done;
    logic [7:0]  new_byte;

    // A half-period ends when the divider counter reaches SCK_DIV-1.
    assign half_done = (div_cnt_reg == DIV_LAST);
    // Byte as it stands once the current MISO bit is appended (MSB first).
    assign new_byte  = {byte_sr_reg, bus.spi_miso};

    assign bus.spi_sck    = sck_reg;
    assign bus.spi_mosi   = mosi_reg;
    assign bus.spi_cs     = cs_reg;
    assign bus.itcm_we    = we_reg;
    assign bus.itcm_addr  = addr_reg;
    assign bus.itcm_wdata = wdata_reg;
    assign bus.core_hold  = hold_reg;
    assign bus.boot_done  = done_reg;

    // Boot sequencer: SCK generation, command shift-out, data capture and
    // ITCM writes, all with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            div_cnt_reg   <= 8'd0;
            bit_cnt_reg   <= 5'd0;
            cmd_sr_reg    <= 32'd0;
            byte_sr_reg   <= 7'd0;
            word_sr_reg   <= 24'd0;
            word_idx_reg  <= 10'd0;
            last_word_reg <= 1'b0;
            sck_reg       <= 1'b0;
            mosi_reg      <= 1'b0;
            cs_reg        <= 1'b1;
            we_reg        <= 1'b0;
            addr_reg      <= 12'd0;
            wdata_reg     <= 32'd0;
            hold_reg      <= 1'b1;
            done_reg      <= 1'b0;
        end else begin
            we_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Select the flash and present the first command bit.
                    state_reg   <= CS_SETUP;
                    cs_reg      <= 1'b0;
                    cmd_sr_reg  <= READ_CMD;
                    mosi_reg    <= READ_CMD[31];
                    div_cnt_reg <= 8'd0;
                end

                CS_SETUP: begin
                    if (half_done) begin
                        div_cnt_reg <= 8'd0;
                        state_reg   <= CMD;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 8'd1;
                    end
                end

                CMD: begin
                    if (half_done) begin
                        div_cnt_reg <= 8'd0;
                        sck_reg     <= ~sck_reg;
                        if (sck_reg) begin
                            // Falling edge: advance to the next command bit.
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            if (bit_cnt_reg == 5'd31) begin
                                state_reg <= DATA;
                                mosi_reg  <= 1'b0;
                            end else begin
                                cmd_sr_reg <= {cmd_sr_reg[30:0], 1'b0};
                                mosi_reg   <= cmd_sr_reg[30];
                            end
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 8'd1;
                    end
                end

                DATA: begin
                    if (half_done) begin
                        div_cnt_reg <= 8'd0;
                        if (sck_reg) begin
                            // Falling edge; the one after the final sample ends the burst.
                            sck_reg <= 1'b0;
                            if (last_word_reg) begin
                                state_reg <= CS_HOLD;
                            end
                        end else begin
                            // Rising edge: sample MISO.
                            sck_reg     <= 1'b1;
                            byte_sr_reg <= new_byte[6:0];
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            if (bit_cnt_reg[2:0] == 3'd7) begin
                                // Later bytes land higher, so byte 0 ends in bits 7:0.
                                word_sr_reg <= {new_byte, word_sr_reg[23:8]};
                            end
                            if (bit_cnt_reg == 5'd31) begin
                                we_reg    <= 1'b1;
                                addr_reg  <= {word_idx_reg, 2'b00};
                                wdata_reg <= {new_byte, word_sr_reg};
                                if (word_idx_reg == LAST_WORD) begin
                                    last_word_reg <= 1'b1;
                                end else begin
                                    word_idx_reg <= word_idx_reg + 10'd1;
                                end
                            end
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 8'd1;
                    end
                end

                CS_HOLD: begin
                    if (half_done) begin
                        div_cnt_reg <= 8'd0;
                        cs_reg      <= 1'b1;
                        hold_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        state_reg   <= DONE;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 8'd1;
                    end
                end

                DONE: begin
                    state_reg <= DONE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_boot_loader.sv
// Bench for spi_flash_boot_loader: two instances (SCK_DIV=2 base 0 with a
// fixed program, SCK_DIV=3 base 0x012345 with random contents and MISO
// glitches while SCK is high), each with a flash model and a bus monitor.
module tb_spi_flash_boot_loader;
    localparam int BW = 4;
    localparam int NB = 4 * BW;

    typedef struct packed {
        logic        sck;
        logic        mosi;
        logic        cs;
        logic        we;
        logic        hold;
        logic        done;
        logic [11:0] addr;
        logic [31:0] wdata;
    } out_t;

    typedef struct {
        int cyc;
        int done_at;
        int wr_count;
        int cs_falls;
        int done_chg;
        int hold_chg;
        int chg_apart;
        int late_we;
        int long_we;
        int mosi_bad;
        int phase_bad;
        int toggles;
        int sck_cs_bad;
        int run_len;
        logic [7:0][11:0] wr_addr;
        logic [7:0][31:0] wr_data;
    } mon_t;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [11:0] addr;
        logic [31:0] data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_v [2];
    logic [7:0]  flash_mem [2][NB];
    logic [31:0] exp_word [2][BW];
    logic [11:0] exp_addr [2][BW];
    vec_t        tbl [BW];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int          DIV    = (gi == 0) ? 2 : 3;
        localparam logic [23:0] BASE   = (gi == 0) ? 24'h000000 : 24'h012345;
        localparam bit          GLITCH = (gi == 1);

        spi_flash_boot_loader_if bus ();
        out_t        o_w;
        mon_t        mon;
        logic [31:0] cmd_word;
        int          rise_cnt;
        int          bit_idx;
        logic [7:0]  fbyte;
        logic        sck_q;
        logic        p_sck, p_cs, p_mosi, p_we, p_done, p_hold;

        spi_flash_boot_loader #(
            .BOOT_WORDS     (BW),
            .FLASH_BASE_ADDR(BASE),
            .SCK_DIV        (DIV)
        ) u_dut (
            .clk(clk),
            .rst(rst_v[gi]),
            .bus(bus)
        );

        assign o_w = {bus.spi_sck, bus.spi_mosi, bus.spi_cs, bus.itcm_we,
                      bus.core_hold, bus.boot_done, bus.itcm_addr, bus.itcm_wdata};

        // Flash model: captures the command on SCK rises, shifts data out on falls.
        always @(bus.spi_sck or bus.spi_cs) begin
            if (bus.spi_cs) begin
                rise_cnt     = 0;
                bit_idx      = 0;
                bus.spi_miso = 1'b0;
            end else if (bus.spi_sck && !sck_q) begin
                if (rise_cnt < 32) begin
                    cmd_word = (rise_cnt == 0) ? {31'd0, bus.spi_mosi} : {cmd_word[30:0], bus.spi_mosi};
                end else if (GLITCH) begin
                    bus.spi_miso = ~bus.spi_miso;
                end
                rise_cnt++;
            end else if (!bus.spi_sck && sck_q) begin
                if (rise_cnt >= 32) begin
                    if (bit_idx < 8 * NB) begin
                        fbyte        = flash_mem[gi][bit_idx / 8];
                        bus.spi_miso = fbyte[3'(7 - (bit_idx % 8))];
                    end else begin
                        bus.spi_miso = 1'b0;
                    end
                    bit_idx++;
                end
            end
            sck_q = bus.spi_sck;
        end

        // Bus monitor sampled on the falling clk edge.
        always @(negedge clk) begin
            if (rst_v[gi]) begin
                mon.cyc = 0;        mon.done_at = -1;  mon.wr_count = 0;
                mon.cs_falls = 0;   mon.done_chg = 0;  mon.hold_chg = 0;
                mon.chg_apart = 0;  mon.late_we = 0;   mon.long_we = 0;
                mon.mosi_bad = 0;   mon.phase_bad = 0; mon.toggles = 0;
                mon.sck_cs_bad = 0; mon.run_len = 0;
                p_sck = 1'b0; p_cs = 1'b1; p_mosi = 1'b0;
                p_we = 1'b0;  p_done = 1'b0; p_hold = 1'b1;
            end else begin
                mon.cyc++;
                if (bus.itcm_we) begin
                    if (mon.wr_count < 8) begin
                        mon.wr_addr[mon.wr_count] = bus.itcm_addr;
                        mon.wr_data[mon.wr_count] = bus.itcm_wdata;
                    end
                    mon.wr_count++;
                    if (p_we) mon.long_we++;
                    if (bus.boot_done) mon.late_we++;
                end
                if (bus.boot_done != p_done) begin
                    mon.done_chg++;
                    if (bus.boot_done && mon.done_at < 0) mon.done_at = mon.cyc;
                end
                if (bus.core_hold != p_hold) mon.hold_chg++;
                if ((bus.boot_done != p_done) != (bus.core_hold != p_hold)) mon.chg_apart++;
                if (p_cs && !bus.spi_cs) mon.cs_falls++;
                if (bus.spi_cs && bus.spi_sck) mon.sck_cs_bad++;
                if (!bus.spi_cs && !p_cs && (bus.spi_mosi != p_mosi) && !(p_sck && !bus.spi_sck))
                    mon.mosi_bad++;
                if (bus.spi_cs) begin
                    mon.run_len = 0;
                end else if (bus.spi_sck != p_sck) begin
                    if (mon.run_len != 0 && mon.run_len != DIV) mon.phase_bad++;
                    mon.run_len = 1;
                    mon.toggles++;
                end else if (mon.run_len != 0) begin
                    mon.run_len++;
                end
                p_sck = bus.spi_sck; p_cs = bus.spi_cs; p_mosi = bus.spi_mosi;
                p_we = bus.itcm_we;  p_done = bus.boot_done; p_hold = bus.core_hold;
            end
        end
    end

    function automatic out_t outs(input int inst);
        if (inst == 0) return g_inst[0].o_w;
        return g_inst[1].o_w;
    endfunction

    function automatic mon_t mon_of(input int inst);
        if (inst == 0) return g_inst[0].mon;
        return g_inst[1].mon;
    endfunction

    function automatic logic [31:0] cmd_of(input int inst);
        if (inst == 0) return g_inst[0].cmd_word;
        return g_inst[1].cmd_word;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input int inst, input string tag);
        out_t o;
        o = outs(inst);
        check($sformatf("%s_sck_%0d", tag, inst),   32'(o.sck),   32'd0);
        check($sformatf("%s_mosi_%0d", tag, inst),  32'(o.mosi),  32'd0);
        check($sformatf("%s_cs_%0d", tag, inst),    32'(o.cs),    32'd1);
        check($sformatf("%s_we_%0d", tag, inst),    32'(o.we),    32'd0);
        check($sformatf("%s_addr_%0d", tag, inst),  32'(o.addr),  32'd0);
        check($sformatf("%s_wdata_%0d", tag, inst), o.wdata,      32'd0);
        check($sformatf("%s_hold_%0d", tag, inst),  32'(o.hold),  32'd1);
        check($sformatf("%s_done_%0d", tag, inst),  32'(o.done),  32'd0);
    endtask

    task automatic wait_done(input int inst, input int budget);
        int   n;
        out_t o;
        n = 0;
        o = outs(inst);
        while (!o.done && n < budget) begin
            @(negedge clk);
            o = outs(inst);
            n++;
        end
        check($sformatf("done_in_budget_%0d", inst), 32'(o.done), 32'd1);
    endtask

    task automatic wait_writes(input int inst, input int count, input int budget);
        int   n;
        mon_t m;
        n = 0;
        m = mon_of(inst);
        while (m.wr_count < count && n < budget) begin
            @(negedge clk);
            m = mon_of(inst);
            n++;
        end
        check($sformatf("writes_in_budget_%0d", inst), 32'(m.wr_count >= count), 32'd1);
    endtask

    // Compares one completed boot of an instance against the reference model.
    task automatic verify(input int inst, input logic [31:0] exp_cmd, input int div);
        mon_t m;
        out_t o;
        int   lat;
        m   = mon_of(inst);
        o   = outs(inst);
        lat = 2 + 2 * div + 64 * div * (1 + BW);
        check($sformatf("cmd_word_%0d", inst), cmd_of(inst), exp_cmd);
        check($sformatf("write_count_%0d", inst), 32'(m.wr_count), 32'(BW));
        for (int i = 0; i < BW; i++) begin
            $display("inst %0d write %0d addr=0x%03h data=0x%08h", inst, i, m.wr_addr[i], m.wr_data[i]);
            check($sformatf("wr_addr_%0d_%0d", inst, i), 32'(m.wr_addr[i]), 32'(exp_addr[inst][i]));
            check($sformatf("wr_data_%0d_%0d", inst, i), m.wr_data[i], exp_word[inst][i]);
        end
        check($sformatf("cs_falls_%0d", inst),      32'(m.cs_falls),   32'd1);
        check($sformatf("done_changes_%0d", inst),  32'(m.done_chg),   32'd1);
        check($sformatf("hold_changes_%0d", inst),  32'(m.hold_chg),   32'd1);
        check($sformatf("done_hold_apart_%0d", inst), 32'(m.chg_apart), 32'd0);
        check($sformatf("we_after_done_%0d", inst), 32'(m.late_we),    32'd0);
        check($sformatf("we_long_%0d", inst),       32'(m.long_we),    32'd0);
        check($sformatf("mosi_unstable_%0d", inst), 32'(m.mosi_bad),   32'd0);
        check($sformatf("sck_phase_len_%0d", inst), 32'(m.phase_bad),  32'd0);
        check($sformatf("sck_toggles_%0d", inst),   32'(m.toggles),    32'(64 * (1 + BW)));
        check($sformatf("sck_high_cs_high_%0d", inst), 32'(m.sck_cs_bad), 32'd0);
        check($sformatf("final_cs_%0d", inst),      32'(o.cs),         32'd1);
        check($sformatf("final_hold_%0d", inst),    32'(o.hold),       32'd0);
        checks++;
        if (m.done_at < lat - 2 || m.done_at > lat + 2) begin
            failures++;
            $display("FAIL latency_%0d: got %0d cycles, expected %0d +/- 2", inst, m.done_at, lat);
        end
    endtask

    initial begin
        out_t o;
        rst_v[0] = 1'b1;
        rst_v[1] = 1'b1;

        // {flash bytes 0..3, expected ITCM address, expected ITCM word}
        tbl[0] = '{8'h13, 8'h00, 8'h00, 8'h00, 12'h000, 32'h00000013};
        tbl[1] = '{8'h93, 8'h00, 8'h10, 8'h00, 12'h004, 32'h00100093};
        tbl[2] = '{8'h13, 8'h01, 8'h20, 8'h00, 12'h008, 32'h00200113};
        tbl[3] = '{8'h6F, 8'h00, 8'h00, 8'h00, 12'h00C, 32'h0000006F};
        for (int i = 0; i < BW; i++) begin
            flash_mem[0][4 * i]     = tbl[i].b0;
            flash_mem[0][4 * i + 1] = tbl[i].b1;
            flash_mem[0][4 * i + 2] = tbl[i].b2;
            flash_mem[0][4 * i + 3] = tbl[i].b3;
            exp_addr[0][i] = tbl[i].addr;
            exp_word[0][i] = tbl[i].data;
        end

        // Random image for the second instance; words are little-endian byte sums.
        for (int j = 0; j < NB; j++) flash_mem[1][j] = 8'($urandom_range(0, 255));
        for (int i = 0; i < BW; i++) begin
            exp_addr[1][i] = 12'(4 * i);
            exp_word[1][i] = 32'(flash_mem[1][4 * i])
                           + 32'(flash_mem[1][4 * i + 1]) * 32'd256
                           + 32'(flash_mem[1][4 * i + 2]) * 32'd65536
                           + 32'(flash_mem[1][4 * i + 3]) * 32'd16777216;
        end

        repeat (3) @(posedge clk);
        #2;
        check_idle_outputs(0, "reset");
        check_idle_outputs(1, "reset");

        @(posedge clk);
        #2;
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        wait_done(0, 3000);
        wait_done(1, 3000);
        repeat (10) @(negedge clk);
        verify(0, 32'h03000000, 2);
        verify(1, 32'h03012345, 3);

        // Fresh boot of instance 0, interrupted by reset during word 2.
        @(posedge clk);
        #2;
        rst_v[0] = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_v[0] = 1'b0;
        wait_writes(0, 2, 2000);
        repeat (40) @(posedge clk);
        #2;
        o = outs(0);
        check("pre_reset_cs_low", 32'(o.cs), 32'd0);
        rst_v[0] = 1'b1;
        #1;
        check_idle_outputs(0, "midrst");
        repeat (3) @(posedge clk);
        #2;
        rst_v[0] = 1'b0;
        wait_done(0, 3000);
        repeat (10) @(negedge clk);
        verify(0, 32'h03000000, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
